// File: rtl/core_pkg.sv
// Shared Sv32 types for the LETC core MMU: PTE layout, walker states, walk constants.
package core_pkg;

    localparam int SV32_LEVELS = 2;
    localparam int PTE_BYTES   = 4;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } sv32_pte_t;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        RESP
    } ptw_state_t;

endpackage

// File: rtl/core_ptw_pte_check.sv
// Combinational Sv32 PTE classifier shared by both walk levels.
module core_ptw_pte_check
    import core_pkg::*;
(
    input  logic [31:0] pte,
    input  logic        level1,
    output logic        is_leaf,
    output logic        page_fault,
    output logic        misaligned
);

    sv32_pte_t p;
    logic      unused_ok;

    assign p          = sv32_pte_t'(pte);
    assign is_leaf    = p.r | p.x;
    // A level-1 leaf maps a 4 MiB page, so its low PPN must be zero.
    assign misaligned = level1 & is_leaf & (p.ppn0 != 10'd0);
    // At level 0 there is no further table, so a pointer PTE is a fault.
    assign page_fault = ~p.v | (~p.r & p.w) | misaligned | (~level1 & ~is_leaf);

    assign unused_ok = &{1'b0, p.ppn1, p.rsw, p.d, p.a, p.g, p.u};

endmodule

// File: rtl/core_ptw.sv
// Sv32 two-level hardware page-table walker; owns one memory read port.
module core_ptw
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] csr_satp_val,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_vpn,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_pte,
    output logic        rsp_superpage,
    output logic        rsp_page_fault,
    output logic        rsp_access_fault,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [33:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err
);

    ptw_state_t state, state_next;
    logic [9:0] vpn0_q;
    logic       level1, in_wait, accept, pte_take;
    logic       is_leaf, pte_fault, misaligned;
    logic       unused_ok;

    assign level1   = (state == L1_WAIT);
    assign in_wait  = (state == L1_WAIT) || (state == L0_WAIT);
    assign accept   = (state == IDLE) && req_valid;
    assign pte_take = in_wait && mem_rsp_valid;

    core_ptw_pte_check u_pte_check (
        .pte        (mem_rsp_data),
        .level1     (level1),
        .is_leaf    (is_leaf),
        .page_fault (pte_fault),
        .misaligned (misaligned)
    );

    assign req_ready     = (state == IDLE);
    assign mem_req_valid = (state == L1_REQ) || (state == L0_REQ);
    assign rsp_valid     = (state == RESP);

    assign unused_ok = &{1'b0, misaligned, csr_satp_val[30:22]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = csr_satp_val[31] ? L1_REQ : RESP;
            L1_REQ:  if (mem_req_ready) state_next = L1_WAIT;
            L1_WAIT: if (mem_rsp_valid) begin
                if (mem_rsp_err || pte_fault || is_leaf) state_next = RESP;
                else                                     state_next = L0_REQ;
            end
            L0_REQ:  if (mem_req_ready) state_next = L0_WAIT;
            L0_WAIT: if (mem_rsp_valid) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The root PPN lives only in mem_req_addr from accept onward, so later
    // satp writes cannot disturb a walk in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpn0_q           <= 10'd0;
            mem_req_addr     <= 34'd0;
            rsp_pte          <= 32'd0;
            rsp_superpage    <= 1'b0;
            rsp_page_fault   <= 1'b0;
            rsp_access_fault <= 1'b0;
        end else if (accept) begin
            vpn0_q           <= req_vpn[9:0];
            mem_req_addr     <= {csr_satp_val[21:0], req_vpn[19:10], 2'b00};
            rsp_pte          <= 32'd0;
            rsp_superpage    <= 1'b0;
            rsp_page_fault   <= ~csr_satp_val[31];
            rsp_access_fault <= 1'b0;
        end else if (pte_take) begin
            rsp_pte <= mem_rsp_data;
            if (mem_rsp_err)    rsp_access_fault <= 1'b1;
            else if (pte_fault) rsp_page_fault   <= 1'b1;
            else if (is_leaf)   rsp_superpage    <= level1;
            else                mem_req_addr     <= {mem_rsp_data[31:10], vpn0_q, 2'b00};
        end
    end

endmodule

// File: tb/tb_core_ptw.sv
// Directed bench for core_ptw with a one-cycle memory model and a response scoreboard.
module tb_core_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] csr_satp_val;
    logic        req_valid, req_ready;
    logic [19:0] req_vpn;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_pte;
    logic        rsp_superpage, rsp_page_fault, rsp_access_fault;
    logic        mem_req_valid, mem_req_ready;
    logic [33:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;

    typedef struct {
        logic [31:0] pte;
        logic        sp;
        logic        pf;
        logic        af;
    } exp_t;

    exp_t        sb[$];
    logic [33:0] addr_q[$];
    logic [31:0] pmem[logic [33:0]];
    int          acc_cnt;
    logic        err_en;
    logic [33:0] err_addr;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    core_ptw dut (
        .clk              (clk),
        .rst              (rst),
        .csr_satp_val     (csr_satp_val),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_vpn          (req_vpn),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_pte          (rsp_pte),
        .rsp_superpage    (rsp_superpage),
        .rsp_page_fault   (rsp_page_fault),
        .rsp_access_fault (rsp_access_fault),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data),
        .mem_rsp_err      (mem_rsp_err)
    );

    // Single-cycle memory: answers the cycle after each request handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= 32'd0;
            mem_rsp_err   <= 1'b0;
        end else begin
            mem_rsp_valid <= mem_req_valid && mem_req_ready;
            mem_rsp_err   <= mem_req_valid && mem_req_ready && err_en && (mem_req_addr == err_addr);
            mem_rsp_data  <= pmem.exists(mem_req_addr) ? pmem[mem_req_addr] : 32'd0;
            if (mem_req_valid && mem_req_ready) begin
                acc_cnt <= acc_cnt + 1;
                addr_q.push_back(mem_req_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic walk(input logic [31:0] satp, input logic [19:0] vpn, input logic [31:0] e_pte,
                        input logic e_sp, input logic e_pf, input logic e_af,
                        input int e_lat, input int e_acc, input int mstall, input int rstall);
        exp_t        e;
        int          cyc;
        int          acc0;
        logic [33:0] a0;
        e.pte = e_pte; e.sp = e_sp; e.pf = e_pf; e.af = e_af;
        sb.push_back(e);
        acc0 = acc_cnt;
        @(negedge clk);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        csr_satp_val  = satp;
        req_vpn       = vpn;
        req_valid     = 1'b1;
        mem_req_ready = (mstall == 0);
        rsp_ready     = (rstall == 0);
        @(negedge clk);
        req_valid    = 1'b0;
        csr_satp_val = 32'h8000_0ABC;
        cyc = 1;
        a0 = {satp[21:0], vpn[19:10], 2'b00};
        for (int i = 0; i < mstall; i++) begin
            chk("mreq_valid_hold", {63'd0, mem_req_valid}, 64'd1);
            chk("mreq_addr_hold", {30'd0, mem_req_addr}, {30'd0, a0});
            @(negedge clk);
            cyc++;
        end
        mem_req_ready = 1'b1;
        while (!rsp_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
        chk("latency", 64'(cyc), 64'(e_lat));
        chk("accesses", 64'(acc_cnt - acc0), 64'(e_acc));
        chk("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i <= rstall; i++) begin
                chk("rsp_pte", {32'd0, rsp_pte}, {32'd0, e.pte});
                chk("rsp_flags", {61'd0, rsp_superpage, rsp_page_fault, rsp_access_fault},
                    {61'd0, e.sp, e.pf, e.af});
                if (i < rstall) begin
                    chk("rsp_hold_valid", {62'd0, rsp_valid, req_ready}, 64'd2);
                    @(negedge clk);
                end
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_valids", {62'd0, rsp_valid, mem_req_valid}, 64'd0);
        chk("rst_flags", {61'd0, rsp_superpage, rsp_page_fault, rsp_access_fault}, 64'd0);
        chk("rst_pte", {32'd0, rsp_pte}, 64'd0);
        chk("rst_addr", {30'd0, mem_req_addr}, 64'd0);
    endtask

    initial begin
        int base;
        rst = 1'b1; csr_satp_val = 32'd0; req_valid = 1'b0; req_vpn = 20'd0;
        rsp_ready = 1'b1; mem_req_ready = 1'b1; err_en = 1'b0; err_addr = 34'd0; acc_cnt = 0;
        pmem[34'h100004] = 32'h0008_0001;
        pmem[34'h200004] = 32'h1234_50CF;
        pmem[34'h100008] = 32'h2000_00CF;
        pmem[34'h10000C] = 32'h2000_04CF;
        pmem[34'h100010] = 32'h0000_00CE;
        pmem[34'h100014] = 32'h0000_0005;
        pmem[34'h100018] = 32'h000C_0001;
        pmem[34'h300004] = 32'h0000_0001;
        pmem[34'h10001C] = 32'h000C_0001;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;

        base = addr_q.size();
        walk(32'h8000_0100, 20'h00401, 32'h1234_50CF, 1'b0, 1'b0, 1'b0, 5, 2, 0, 0);
        chk("addr_log_n", 64'(addr_q.size() - base), 64'd2);
        if (addr_q.size() - base == 2) begin
            chk("addr_l1", {30'd0, addr_q[base]},   64'h100004);
            chk("addr_l0", {30'd0, addr_q[base+1]}, 64'h200004);
        end

        walk(32'h8000_0100, 20'h00801, 32'h2000_00CF, 1'b1, 1'b0, 1'b0, 3, 1, 0, 0);
        walk(32'h8000_0100, 20'h00C01, 32'h2000_04CF, 1'b0, 1'b1, 1'b0, 3, 1, 0, 0);
        walk(32'h8000_0100, 20'h01001, 32'h0000_00CE, 1'b0, 1'b1, 1'b0, 3, 1, 0, 0);
        walk(32'h8000_0100, 20'h01401, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 3, 1, 0, 0);
        walk(32'h8000_0100, 20'h01801, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 5, 2, 0, 0);

        err_en = 1'b1; err_addr = 34'h300004;
        walk(32'h8000_0100, 20'h01C01, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 5, 2, 0, 0);
        err_en = 1'b0;

        walk(32'h8000_0100, 20'h00401, 32'h1234_50CF, 1'b0, 1'b0, 1'b0, 8, 2, 3, 0);
        walk(32'h8000_0100, 20'h00801, 32'h2000_00CF, 1'b1, 1'b0, 1'b0, 3, 1, 0, 4);
        walk(32'h0000_0100, 20'h00401, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0);

        // Reset while the level-0 read is outstanding.
        @(negedge clk);
        csr_satp_val = 32'h8000_0100; req_vpn = 20'h00401; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {62'd0, req_ready, rsp_valid}, 64'd0);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs();
        walk(32'h8000_0100, 20'h00401, 32'h1234_50CF, 1'b0, 1'b0, 1'b0, 5, 2, 0, 0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
